// File: rtl/regfile8x16_wr_pkg.sv
// regfile8x16_wr_pkg: shared widths and types for the register file slice
package regfile8x16_wr_pkg;
  localparam int REG_W = 16;
  localparam int REG_SEL_W = 3;
  localparam int NUM_REGS = 8;
  typedef logic [REG_W-1:0] reg_data_t;
  typedef logic [REG_SEL_W-1:0] reg_sel_t;
endpackage

// File: rtl/regfile8x16_wr_decode3_8.sv
// decode3_8: 3-to-8 one-hot decoder for the writeback register index
module decode3_8
  import regfile8x16_wr_pkg::*;
(
  input  reg_sel_t              sel,
  output logic [NUM_REGS-1:0]   onehot
);
  assign onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << sel;
endmodule

// File: rtl/regfile8x16_wr.sv
// regfile8x16_wr: 8x16 register file, two async read ports, one sync write port
// REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding
module regfile8x16_wr
  import regfile8x16_wr_pkg::*;
#(
  parameter int WIDTH = REG_W,
  parameter int NREGS = NUM_REGS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       read1regsel,
  input  logic [2:0]       read2regsel,
  input  logic [2:0]       writeregsel,
  input  logic [WIDTH-1:0] writedata,
  input  logic             write,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data
);
  logic [WIDTH-1:0]    regs [NREGS];
  logic [NUM_REGS-1:0] onehot;
  logic [NUM_REGS-1:0] we;

  decode3_8 u_dec (.sel(writeregsel), .onehot(onehot));

  assign we = onehot & {NUM_REGS{write}};

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++)
      if (rst) regs[i] <= '0;
      else if (we[i]) regs[i] <= writedata;
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset since the write will be discarded
  assign read1data = (write && !rst && writeregsel == read1regsel) ? writedata : regs[read1regsel];
  assign read2data = (write && !rst && writeregsel == read2regsel) ? writedata : regs[read2regsel];
`else
  assign read1data = regs[read1regsel];
  assign read2data = regs[read2regsel];
`endif
endmodule

// File: tb/tb_regfile8x16_wr.sv
// tb_regfile8x16_wr: directed self-checking bench for regfile8x16_wr
module tb_regfile8x16_wr;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  read1regsel, read2regsel, writeregsel;
  logic [15:0] writedata;
  logic        write;
  logic [15:0] read1data, read2data;
  int          n_tests = 0;
  int          n_fail = 0;

  regfile8x16_wr dut (
    .clk(clk), .rst(rst), .read1regsel(read1regsel), .read2regsel(read2regsel),
    .writeregsel(writeregsel), .writedata(writedata), .write(write),
    .read1data(read1data), .read2data(read2data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < 8; i++) begin
      write = 1'b1; writeregsel = 3'(i); writedata = 16'(16'h1111 * i);
      tick();
    end
    write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write = 1'b1; writeregsel = 3'd3; writedata = 16'hBEEF;
    read1regsel = 3'd0; read2regsel = 3'd0;
    tick();
    rst = 1'b0; write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read1regsel = 3'(i); read2regsel = 3'(i); #1;
      chk($sformatf("reset_r1_%0d", i), read1data, 16'h0000);
      chk($sformatf("reset_r2_%0d", i), read2data, 16'h0000);
    end
    load_all();
    for (int i = 0; i < 8; i++) begin
      read1regsel = 3'(i); read2regsel = 3'(7 - i); #1;
      chk($sformatf("sweep_p1_%0d", i), read1data, 16'(16'h1111 * i));
      chk($sformatf("sweep_p2_%0d", 7 - i), read2data, 16'(16'h1111 * (7 - i)));
      read2regsel = 3'(i); #1;
      chk($sformatf("same_idx_%0d", i), read2data, 16'(16'h1111 * i));
    end
    write = 1'b1; writeregsel = 3'd5; writedata = 16'h00AA;
    tick();
    writedata = 16'h5555; read1regsel = 3'd5; #1;
`ifdef REGFILE_BYPASS_EN
    chk("hazard_same_cycle", read1data, 16'h5555);
`else
    chk("hazard_same_cycle", read1data, 16'h00AA);
`endif
    tick();
    write = 1'b0; #1;
    chk("hazard_next_cycle", read1data, 16'h5555);
    write = 1'b0; writeregsel = 3'd2; writedata = 16'hFFFF;
    repeat (4) tick();
    read1regsel = 3'd2; #1;
    chk("write_disable_r2", read1data, 16'h2222);
    rst = 1'b1; write = 1'b1; writeregsel = 3'd6; writedata = 16'hCAFE;
    read1regsel = 3'd6; read2regsel = 3'd6; #1;
    chk("rst_no_bypass_p1", read1data, 16'h6666);
    chk("rst_no_bypass_p2", read2data, 16'h6666);
    tick();
    rst = 1'b0; write = 1'b0; #1;
    chk("rst_mid_r6", read1data, 16'h0000);
    read1regsel = 3'd5; #1;
    chk("rst_mid_r5", read1data, 16'h0000);
    load_all();
    write = 1'b1; writeregsel = 3'd4; writedata = 16'hA5A5;
    read1regsel = 3'd3; read2regsel = 3'd5; #1;
    chk("iso_during_p1_r3", read1data, 16'h3333);
    chk("iso_during_p2_r5", read2data, 16'h5555);
    tick();
    write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read2regsel = 3'(i); #1;
      chk($sformatf("iso_r%0d", i), read2data, (i == 4) ? 16'hA5A5 : 16'(16'h1111 * i));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
